// File: rtl/case_3_sdiv_10s_4s_10_seq.sv
// Sequential signed divider: restoring radix-2, one quotient bit per cycle, C truncation.
// Optional remainder output is built only when CASE_3_SDIV_REM_EN is defined.
module case_3_sdiv_10s_4s_10_seq #(
    parameter int unsigned din0_WIDTH = 10,
    parameter int unsigned din1_WIDTH = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [din0_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CW = $clog2(din0_WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(din0_WIDTH);

    typedef enum logic [1:0] {st_idle, st_calc, st_fix, st_done} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [din0_WIDTH-1:0]  dvd;      // |dividend| shifting out, quotient shifting in
    logic [din1_WIDTH-1:0]  dvs;
    logic [din1_WIDTH:0]    prem;
    logic                   qsign;
    logic                   dbz;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [din0_WIDTH-1:0]  quot_r;
    logic                   dbz_r;

    logic [din0_WIDTH-1:0]  abs0;
    logic [din1_WIDTH-1:0]  abs1;
    logic [din1_WIDTH+1:0]  shifted;
    logic [din1_WIDTH+1:0]  trial;
    logic [din0_WIDTH-1:0]  quot_fix;

`ifdef CASE_3_SDIV_REM_EN
    logic                   sign0;
    logic [din1_WIDTH-1:0]  rem_r;
    logic [din1_WIDTH-1:0]  rem_mag;
    logic [din1_WIDTH-1:0]  rem_fix;
`endif

    always_comb begin
        abs0     = din0[din0_WIDTH-1] ? -din0 : din0;
        abs1     = din1[din1_WIDTH-1] ? -din1 : din1;
        shifted  = {prem, dvd[din0_WIDTH-1]};
        trial    = shifted - {2'b00, dvs};
        // Overflow (-min / -1) wraps naturally: |dividend| = 2^(W-1) reads back as -min.
        quot_fix = dbz ? '1 : (qsign ? -dvd : dvd);
`ifdef CASE_3_SDIV_REM_EN
        rem_mag  = prem[din1_WIDTH-1:0];
        rem_fix  = dbz ? '0 : (sign0 ? -rem_mag : rem_mag);
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= st_idle;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            qsign       <= 1'b0;
            dbz         <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            quot_r      <= '0;
            dbz_r       <= 1'b0;
`ifdef CASE_3_SDIV_REM_EN
            sign0       <= 1'b0;
            rem_r       <= '0;
`endif
        end else begin
            case (state)
                st_idle: begin
                    if (in_valid && in_ready_r) begin
                        dvd        <= abs0;
                        dvs        <= abs1;
                        qsign      <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        dbz        <= (din1 == '0);
                        prem       <= '0;
                        cnt        <= '0;
`ifdef CASE_3_SDIV_REM_EN
                        sign0      <= din0[din0_WIDTH-1];
`endif
                        in_ready_r <= 1'b0;
                        state      <= st_calc;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                st_calc: begin
                    if (cnt == LAST_CNT) begin
                        state <= st_fix;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (!trial[din1_WIDTH+1]) begin
                            prem <= trial[din1_WIDTH:0];
                            dvd  <= {dvd[din0_WIDTH-2:0], 1'b1};
                        end else begin
                            prem <= shifted[din1_WIDTH:0];
                            dvd  <= {dvd[din0_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                st_fix: begin
                    quot_r      <= quot_fix;
                    dbz_r       <= dbz;
`ifdef CASE_3_SDIV_REM_EN
                    rem_r       <= rem_fix;
`endif
                    out_valid_r <= 1'b1;
                    state       <= st_done;
                end
                st_done: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quot        = quot_r;
    assign div_by_zero = dbz_r;
`ifdef CASE_3_SDIV_REM_EN
    assign rem         = rem_r;
`else
    assign rem         = '0;
`endif

endmodule

// File: tb/tb_case_3_sdiv_10s_4s_10_seq.sv
// Directed bench for case_3_sdiv_10s_4s_10_seq: vector table plus backpressure and reset sequences.
module tb_case_3_sdiv_10s_4s_10_seq;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic [9:0] din0 = '0;
    logic [3:0] din1 = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] quot;
    logic [3:0] rem;
    logic       div_by_zero;
    logic       out_valid;
    logic       out_ready = 1'b0;

    case_3_sdiv_10s_4s_10_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .din0        (din0),
        .din1        (din1),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } vec_t;

    vec_t vecs[12];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int exp_rem(input int r);
`ifdef CASE_3_SDIV_REM_EN
        return r;
`else
        return 0;
`endif
    endfunction

    function automatic int sq(input logic [9:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sr(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen high.
    task automatic start_op(input int a, input int b, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge ap_clk);
            guard++;
        end
        check("in_ready before accept", int'(in_ready), 1);
        din0     = 10'(a);
        din1     = 4'(b);
        in_valid = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge ap_clk);
            lat++;
            @(negedge ap_clk);
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        out_ready = 1'b0;
        check("out_valid after handoff", int'(out_valid), 0);
        check("in_ready after handoff", int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        int hq, hr, hz;

        vecs[0]  = '{100,  7,   14,  2, 0};
        vecs[1]  = '{-100, 7,  -14, -2, 0};
        vecs[2]  = '{100, -7,  -14,  2, 0};
        vecs[3]  = '{-100, -8,  12, -4, 0};
        vecs[4]  = '{-512, -1, -512, 0, 0};
        vecs[5]  = '{511,  1,  511,  0, 0};
        vecs[6]  = '{37,   0,   -1,  0, 1};
        vecs[7]  = '{9,    3,    3,  0, 0};
        vecs[8]  = '{-7,   2,   -3, -1, 0};
        vecs[9]  = '{-512, 7,  -73, -1, 0};
        vecs[10] = '{511, -8,  -63,  7, 0};
        vecs[11] = '{0,    5,    0,  0, 0};

        #12;
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset quot", sq(quot), 0);
        check("reset rem", sr(rem), 0);
        check("reset div_by_zero", int'(div_by_zero), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        check("in_ready after reset release", int'(in_ready), 1);

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d latency", i), lat, 12);
            check($sformatf("v%0d quot", i), sq(quot), vecs[i].q);
            check($sformatf("v%0d rem", i), sr(rem), exp_rem(vecs[i].r));
            check($sformatf("v%0d div_by_zero", i), int'(div_by_zero), vecs[i].z);
            handoff();
        end

        // Backpressure: stall 5 cycles while a new request is offered and must be ignored.
        start_op(100, 7, lat);
        check("bp latency", lat, 12);
        hq = sq(quot);
        hr = sr(rem);
        hz = int'(div_by_zero);
        din0     = 10'd1;
        din1     = 4'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            check("bp out_valid held", int'(out_valid), 1);
            check("bp in_ready low", int'(in_ready), 0);
            check("bp quot stable", sq(quot), 14);
            check("bp rem stable", sr(rem), exp_rem(2));
        end
        check("bp quot vs first sample", sq(quot), hq);
        check("bp rem vs first sample", sr(rem), hr);
        check("bp dbz vs first sample", int'(div_by_zero), hz);
        in_valid = 1'b0;
        handoff();
        start_op(-7, 2, lat);
        check("post-bp latency", lat, 12);
        check("post-bp quot", sq(quot), -3);
        handoff();

        // Reset after CALC iteration 4 drops the in-flight division.
        din0     = 10'd123;
        din1     = 4'd4;
        in_valid = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (4) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("midreset in_ready", int'(in_ready), 0);
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset quot", sq(quot), 0);
        check("midreset rem", sr(rem), 0);
        check("midreset div_by_zero", int'(div_by_zero), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        check("in_ready after midreset", int'(in_ready), 1);
        check("no stale out_valid", int'(out_valid), 0);
        start_op(50, 5, lat);
        check("after reset latency", lat, 12);
        check("after reset quot", sq(quot), 10);
        check("after reset rem", sr(rem), 0);
        handoff();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
